spi_master: RTL and testbench

//  SPI mode-3 (CPOL=1, CPHA=1) master shifting one variable-length frame per request, MSB first.

---
 rtl/spi_master_pkg.sv | 34 +++
 rtl/spi_master_clk_tick.sv | 38 +++
 rtl/spi_master.sv | 161 ++++++++++++++++
 tb/tb_spi_master.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_pkg
//   Shared definitions for the SPI mode-3 master:
//     - maximum frame width and the width of the frame-length field
//     - SPI mode-3 clock constants (CPOL=1, CPHA=1)
//     - FSM state type
//     - helper to size the shared half-period / gap counter
// -----------------------------------------------------------------------------
package spi_master_pkg;

  // Widest frame the master can shift (frame length field is nbits-1).
  localparam int unsigned SPI_MAX_BITS = 32;
  localparam int unsigned SPI_NBITS_W  = 5;

  // Mode 3: SCLK idles high. Data is launched on the falling edge and
  // sampled on the rising edge; the FSM below hard-codes that phase.
  localparam logic SPI_CPOL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,   // waiting for a request, spi_ready high
    ST_SETUP,  // CSn low, SCLK high, first MOSI bit presented
    ST_LOW,    // SCLK low half-period
    ST_HIGH,   // SCLK high half-period
    ST_GAP     // CSn high recovery time before ready
  } spi_state_t;

  // Bits needed to count 0 .. max_count-1 (never less than one bit).
  function automatic int unsigned spi_cnt_width(input int unsigned max_count);
    int unsigned w;
    w = $clog2(max_count);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_master_clk_tick.sv
// -----------------------------------------------------------------------------
// spi_master_clk_tick
//   Shared phase counter for the SPI master. Counts 0..i_limit and raises
//   o_tick during the final count; wraps to zero after a tick so every
//   state/phase sees a fresh count. i_restart holds the counter at zero.
//
// Ports
//   clk_in     in  1      system clock
//   nrst       in  1      asynchronous active-low reset
//   i_restart  in  1      hold counter at zero
//   i_limit    in  CNT_W  terminal count (phase length minus one)
//   o_tick     out 1      high on the last cycle of the phase
// -----------------------------------------------------------------------------
module spi_master_clk_tick #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_in,
  input  logic             nrst,
  input  logic             i_restart,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == i_limit);

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI mode-3 (CPOL=1, CPHA=1) master. Shifts one variable-length frame,
//   MSB first, per accepted request and returns the received bits
//   right-aligned in spi_miso_data.
//
// Parameters
//   CLK_DIV  clk_in cycles per SCLK half-period (>=1)
//   CS_GAP   clk_in cycles CSn stays high after a frame before ready (>=1)
//
// Ports
//   clk_in         in   1   system clock, rising edge
//   nrst           in   1   asynchronous active-low reset
//   spi_mosi_data  in   32  frame to send, bit spi_nbits goes first
//   spi_nbits      in   5   frame length minus one
//   spi_request    in   1   level request, taken only when idle and ready
//   spi_ready      out  1   idle, spi_miso_data valid
//   spi_miso_data  out  32  received frame, right-aligned
//   spi_sclk       out  1   serial clock, idles high
//   spi_csn        out  1   chip select, active low
//   spi_mosi       out  1   serial data out
//   spi_miso       in   1   serial data in
// -----------------------------------------------------------------------------
module spi_master
  import spi_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic                    clk_in,
  input  logic                    nrst,
  input  logic [SPI_MAX_BITS-1:0] spi_mosi_data,
  input  logic [SPI_NBITS_W-1:0]  spi_nbits,
  input  logic                    spi_request,
  output logic                    spi_ready,
  output logic [SPI_MAX_BITS-1:0] spi_miso_data,
  output logic                    spi_sclk,
  output logic                    spi_csn,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);

  // One counter serves both the SCLK half-periods and the CSn gap, so it is
  // sized for the longer of the two.
  localparam int unsigned CNT_W =
    spi_cnt_width((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

  spi_state_t                r_state;
  logic [SPI_MAX_BITS-1:0]   r_tx_data;
  logic [SPI_NBITS_W-1:0]    r_bit_cnt;
  logic [SPI_MAX_BITS-1:0]   r_rx_shift;
  logic [SPI_MAX_BITS-1:0]   r_miso_data;
  logic                      r_ready;
  logic                      r_sclk;
  logic                      r_csn;
  logic                      r_mosi;

  logic                      w_tick;
  logic                      w_restart;
  logic [CNT_W-1:0]          w_limit;

  // Counter is parked at zero while idle, so the first SETUP cycle after
  // acceptance starts a full half-period.
  assign w_restart = (r_state == ST_IDLE);
  assign w_limit   = (r_state == ST_GAP) ? GAP_LAST : DIV_LAST;

  spi_master_clk_tick #(
    .CNT_W (CNT_W)
  ) u_clk_tick (
    .clk_in    (clk_in),
    .nrst      (nrst),
    .i_restart (w_restart),
    .i_limit   (w_limit),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_tx_data   <= '0;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_miso_data <= '0;
      r_ready     <= 1'b1;
      r_sclk      <= SPI_CPOL;
      r_csn       <= 1'b1;
      r_mosi      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (spi_request && r_ready) begin
            // Frame and length are captured here; later input changes
            // do not affect the frame in flight.
            r_tx_data  <= spi_mosi_data;
            r_bit_cnt  <= spi_nbits;
            r_mosi     <= spi_mosi_data[spi_nbits];
            r_rx_shift <= '0;
            r_ready    <= 1'b0;
            r_csn      <= 1'b0;
            r_state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (w_tick) begin
            r_sclk  <= 1'b0;
            r_state <= ST_LOW;
          end
        end

        ST_LOW: begin
          if (w_tick) begin
            // Rising SCLK edge: slave data has been stable for a full
            // half-period, sample it now.
            r_sclk     <= 1'b1;
            r_rx_shift <= {r_rx_shift[SPI_MAX_BITS-2:0], spi_miso};
            r_state    <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (w_tick) begin
            if (r_bit_cnt == '0) begin
              r_csn   <= 1'b1;
              r_mosi  <= 1'b0;
              r_state <= ST_GAP;
            end else begin
              r_bit_cnt <= r_bit_cnt - 1'b1;
              r_mosi    <= r_tx_data[r_bit_cnt - 1'b1];
              r_sclk    <= 1'b0;
              r_state   <= ST_LOW;
            end
          end
        end

        ST_GAP: begin
          if (w_tick) begin
            // Result is published on the same edge ready rises, and held
            // until the next frame completes.
            r_miso_data <= r_rx_shift;
            r_ready     <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi_ready     = r_ready;
  assign spi_miso_data = r_miso_data;
  assign spi_sclk      = r_sclk;
  assign spi_csn       = r_csn;
  assign spi_mosi      = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  localparam int unsigned DIV  = 4;
  localparam int unsigned GAP  = 4;
  localparam int unsigned FDIV = 1;
  localparam int unsigned FGAP = 1;

  logic        clk_in = 1'b0;
  logic        nrst   = 1'b0;

  // Main instance (CLK_DIV=4)
  logic [31:0] spi_mosi_data = '0;
  logic [4:0]  spi_nbits     = '0;
  logic        spi_request   = 1'b0;
  logic        spi_ready;
  logic [31:0] spi_miso_data;
  logic        spi_sclk;
  logic        spi_csn;
  logic        spi_mosi;
  logic        spi_miso      = 1'b0;

  // Fast instance (CLK_DIV=1), MISO looped back to MOSI
  logic [31:0] f_mosi_data = '0;
  logic [4:0]  f_nbits     = '0;
  logic        f_request   = 1'b0;
  logic        f_ready;
  logic [31:0] f_miso_data;
  logic        f_sclk;
  logic        f_csn;
  logic        f_mosi;
  logic        f_miso;

  assign f_miso = f_mosi;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  spi_master #(.CLK_DIV(DIV), .CS_GAP(GAP)) dut (
    .clk_in        (clk_in),
    .nrst          (nrst),
    .spi_mosi_data (spi_mosi_data),
    .spi_nbits     (spi_nbits),
    .spi_request   (spi_request),
    .spi_ready     (spi_ready),
    .spi_miso_data (spi_miso_data),
    .spi_sclk      (spi_sclk),
    .spi_csn       (spi_csn),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso)
  );

  spi_master #(.CLK_DIV(FDIV), .CS_GAP(FGAP)) dut_fast (
    .clk_in        (clk_in),
    .nrst          (nrst),
    .spi_mosi_data (f_mosi_data),
    .spi_nbits     (f_nbits),
    .spi_request   (f_request),
    .spi_ready     (f_ready),
    .spi_miso_data (f_miso_data),
    .spi_sclk      (f_sclk),
    .spi_csn       (f_csn),
    .spi_mosi      (f_mosi),
    .spi_miso      (f_miso)
  );

  // ---------------------------------------------------------------------------
  // Bus monitor + slave model for the main instance (sampled on falling clk).
  // Slave drives its word MSB first, changing data on each SCLK fall.
  // ---------------------------------------------------------------------------
  logic [31:0] slave_word  = '0;
  int          slave_nbits = 0;
  int          slave_idx   = -1;
  int          cyc = 0, csn_low = 0, rises = 0, period_err = 0;
  int          frames = 0, gap_run = 0, last_gap = 0, last_rise = -1;
  logic [31:0] mosi_cap  = '0;
  logic        prev_sclk = 1'b1, prev_csn = 1'b1;

  always @(negedge clk_in) begin
    cyc++;
    if (!spi_csn) csn_low++;
    if (spi_csn) gap_run++;
    if (!spi_csn && prev_csn) begin
      last_gap  = gap_run;
      frames++;
      gap_run   = 0;
      slave_idx = slave_nbits;
      last_rise = -1;
    end
    if (!spi_csn && prev_sclk && !spi_sclk) begin
      if (slave_idx >= 0) begin
        spi_miso = slave_word[slave_idx];
        slave_idx--;
      end
    end
    if (!spi_csn && !prev_sclk && spi_sclk) begin
      rises++;
      mosi_cap = {mosi_cap[30:0], spi_mosi};
      if (last_rise >= 0 && (cyc - last_rise) != int'(2 * DIV)) period_err++;
      last_rise = cyc;
    end
    prev_sclk = spi_sclk;
    prev_csn  = spi_csn;
  end

  // Monitor for the fast instance.
  int   f_csn_low = 0, f_rises = 0, f_period_err = 0, f_last_rise = -1;
  logic f_prev_sclk = 1'b1, f_prev_csn = 1'b1;

  always @(negedge clk_in) begin
    if (!f_csn) f_csn_low++;
    if (!f_csn && f_prev_csn) f_last_rise = -1;
    if (!f_csn && !f_prev_sclk && f_sclk) begin
      f_rises++;
      if (f_last_rise >= 0 && (cyc - f_last_rise) != int'(2 * FDIV)) f_period_err++;
      f_last_rise = cyc;
    end
    f_prev_sclk = f_sclk;
    f_prev_csn  = f_csn;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic start_frame(input logic [31:0] d, input logic [4:0] nb,
                             input logic [31:0] sw, output logic rdy_after);
    slave_word  = sw;
    slave_nbits = int'(nb);
    @(negedge clk_in);
    spi_mosi_data = d;
    spi_nbits     = nb;
    spi_request   = 1'b1;
    @(negedge clk_in);
    rdy_after     = spi_ready;
    spi_request   = 1'b0;
    spi_mosi_data = $urandom;
    spi_nbits     = 5'($urandom);
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if (spi_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [31:0] frame_mask(input logic [4:0] nb);
    return 32'hFFFF_FFFF >> (31 - int'(nb));
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (spi_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", spi_ready); end
    checks++; if (spi_miso_data !== 32'h0) begin failures++; $display("FAIL reset_miso_data: got %h expected 00000000", spi_miso_data); end
    checks++; if (spi_sclk !== 1'b1) begin failures++; $display("FAIL reset_sclk: got %b expected 1", spi_sclk); end
    checks++; if (spi_csn !== 1'b1) begin failures++; $display("FAIL reset_csn: got %b expected 1", spi_csn); end
    checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b expected 0", spi_mosi); end
    nrst = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  // Directed vectors (WHO_AM_I, accel read, 1-bit, 32-bit loopback) then random.
  task automatic test_frames();
    logic [31:0] vd[12];
    logic [31:0] vs[12];
    logic [4:0]  vn[12];
    logic [31:0] prev_exp;
    logic        rdy_after, ok;
    vd[0] = 32'h0000_8F00; vn[0] = 5'd15; vs[0] = 32'h0000_0033;
    vd[1] = 32'h00E8_0000; vn[1] = 5'd23; vs[1] = 32'h0000_9A00;
    vd[2] = $urandom;      vn[2] = 5'd0;  vs[2] = $urandom;
    vd[3] = 32'hA5A5_5A5A; vn[3] = 5'd31; vs[3] = 32'hA5A5_5A5A;
    for (int i = 4; i < 12; i++) begin
      vd[i] = $urandom;
      vs[i] = $urandom;
      vn[i] = 5'($urandom_range(0, 31));
    end
    prev_exp = spi_miso_data;
    for (int i = 0; i < 12; i++) begin
      int          r0, c0, p0;
      logic [31:0] m, exp_rx;
      m      = frame_mask(vn[i]);
      exp_rx = vs[i] & m;
      r0 = rises; c0 = csn_low; p0 = period_err;
      start_frame(vd[i], vn[i], vs[i], rdy_after);
      checks++; if (rdy_after !== 1'b0) begin failures++; $display("FAIL frame%0d_ready_low: got %b expected 0", i, rdy_after); end
      checks++; if (spi_miso_data !== prev_exp) begin failures++; $display("FAIL frame%0d_hold_prev: got %h expected %h", i, spi_miso_data, prev_exp); end
      wait_ready(ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL frame%0d_timeout: got ready=%b expected 1", i, spi_ready); end
      checks++; if (spi_miso_data !== exp_rx) begin failures++; $display("FAIL frame%0d_miso_data: got %h expected %h", i, spi_miso_data, exp_rx); end
      checks++; if ((mosi_cap & m) !== (vd[i] & m)) begin failures++; $display("FAIL frame%0d_mosi_stream: got %h expected %h", i, mosi_cap & m, vd[i] & m); end
      checks++; if (rises - r0 != int'(vn[i]) + 1) begin failures++; $display("FAIL frame%0d_sclk_rises: got %0d expected %0d", i, rises - r0, int'(vn[i]) + 1); end
      checks++; if (csn_low - c0 != int'(DIV) * (2 * int'(vn[i]) + 3)) begin failures++; $display("FAIL frame%0d_csn_low: got %0d expected %0d", i, csn_low - c0, int'(DIV) * (2 * int'(vn[i]) + 3)); end
      checks++; if (period_err != p0) begin failures++; $display("FAIL frame%0d_sclk_period: got %0d bad periods expected 0", i, period_err - p0); end
      prev_exp = exp_rx;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, sw;
    int          f0, p0;
    logic        ok;
    d = $urandom; sw = $urandom;
    f0 = frames; p0 = period_err;
    slave_word = sw; slave_nbits = 7;
    @(negedge clk_in);
    spi_mosi_data = d; spi_nbits = 5'd7; spi_request = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      if (frames - f0 >= 3) begin ok = 1'b1; break; end
    end
    spi_request = 1'b0;
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_three_frames: got %0d frames expected 3", frames - f0); end
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL b2b_timeout: got ready=%b expected 1", spi_ready); end
    repeat (10) @(negedge clk_in);
    checks++; if (frames - f0 != 3) begin failures++; $display("FAIL b2b_frame_count: got %0d expected 3", frames - f0); end
    checks++; if (last_gap != int'(GAP) + 1) begin failures++; $display("FAIL b2b_csn_gap: got %0d expected %0d", last_gap, GAP + 1); end
    checks++; if (spi_miso_data !== (sw & 32'hFF)) begin failures++; $display("FAIL b2b_miso_data: got %h expected %h", spi_miso_data, sw & 32'hFF); end
    checks++; if ((mosi_cap & 32'hFF) !== (d & 32'hFF)) begin failures++; $display("FAIL b2b_mosi_stream: got %h expected %h", mosi_cap & 32'hFF, d & 32'hFF); end
    checks++; if (period_err != p0) begin failures++; $display("FAIL b2b_sclk_period: got %0d bad periods expected 0", period_err - p0); end
  endtask

  task automatic test_pulse_midframe();
    logic [31:0] d, sw;
    int          f0, r0;
    logic        rdy_after, ok;
    d = $urandom; sw = $urandom;
    f0 = frames; r0 = rises;
    start_frame(d, 5'd15, sw, rdy_after);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_in);
      if (rises - r0 >= 5) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL pulse_reach_bit5: got %0d rises expected 5", rises - r0); end
    spi_request = 1'b1;
    @(negedge clk_in);
    spi_request = 1'b0;
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL pulse_timeout: got ready=%b expected 1", spi_ready); end
    repeat (20) @(negedge clk_in);
    checks++; if (frames - f0 != 1) begin failures++; $display("FAIL pulse_extra_frame: got %0d frames expected 1", frames - f0); end
    checks++; if (spi_ready !== 1'b1) begin failures++; $display("FAIL pulse_ready_idle: got %b expected 1", spi_ready); end
    checks++; if (spi_miso_data !== (sw & 32'hFFFF)) begin failures++; $display("FAIL pulse_miso_data: got %h expected %h", spi_miso_data, sw & 32'hFFFF); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d, sw;
    int          r0;
    logic        rdy_after, ok;
    r0 = rises;
    start_frame(32'h0000_8F00, 5'd15, 32'h0000_1234, rdy_after);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_in);
      if (rises - r0 >= 7) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_reach_bit7: got %0d rises expected 7", rises - r0); end
    checks++; if (spi_csn !== 1'b0) begin failures++; $display("FAIL rstmid_busy_before: got csn=%b expected 0", spi_csn); end
    #1 nrst = 1'b0;
    #1;
    checks++; if (spi_csn !== 1'b1) begin failures++; $display("FAIL rstmid_csn: got %b expected 1", spi_csn); end
    checks++; if (spi_sclk !== 1'b1) begin failures++; $display("FAIL rstmid_sclk: got %b expected 1", spi_sclk); end
    checks++; if (spi_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b expected 1", spi_ready); end
    checks++; if (spi_miso_data !== 32'h0) begin failures++; $display("FAIL rstmid_miso_data: got %h expected 00000000", spi_miso_data); end
    checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL rstmid_mosi: got %b expected 0", spi_mosi); end
    #1 nrst = 1'b1;
    repeat (2) @(negedge clk_in);
    d = $urandom; sw = $urandom;
    r0 = rises;
    start_frame(d, 5'd15, sw, rdy_after);
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_next_timeout: got ready=%b expected 1", spi_ready); end
    checks++; if (spi_miso_data !== (sw & 32'hFFFF)) begin failures++; $display("FAIL rstmid_next_miso: got %h expected %h", spi_miso_data, sw & 32'hFFFF); end
    checks++; if ((mosi_cap & 32'hFFFF) !== (d & 32'hFFFF)) begin failures++; $display("FAIL rstmid_next_mosi: got %h expected %h", mosi_cap & 32'hFFFF, d & 32'hFFFF); end
    checks++; if (rises - r0 != 16) begin failures++; $display("FAIL rstmid_next_rises: got %0d expected 16", rises - r0); end
  endtask

  task automatic test_div1_timing();
    logic [31:0] d;
    int          c0, r0, p0;
    logic        ok;
    d  = $urandom;
    c0 = f_csn_low; r0 = f_rises; p0 = f_period_err;
    checks++; if (f_ready !== 1'b1) begin failures++; $display("FAIL div1_ready_idle: got %b expected 1", f_ready); end
    @(negedge clk_in);
    f_mosi_data = d; f_nbits = 5'd15; f_request = 1'b1;
    @(negedge clk_in);
    f_request = 1'b0; f_mosi_data = $urandom; f_nbits = 5'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_in);
      if (f_ready) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL div1_timeout: got ready=%b expected 1", f_ready); end
    checks++; if (f_csn_low - c0 != 33) begin failures++; $display("FAIL div1_csn_low: got %0d expected 33", f_csn_low - c0); end
    checks++; if (f_rises - r0 != 16) begin failures++; $display("FAIL div1_rises: got %0d expected 16", f_rises - r0); end
    checks++; if (f_period_err != p0) begin failures++; $display("FAIL div1_sclk_period: got %0d bad periods expected 0", f_period_err - p0); end
    checks++; if (f_miso_data !== (d & 32'hFFFF)) begin failures++; $display("FAIL div1_loopback: got %h expected %h", f_miso_data, d & 32'hFFFF); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_pulse_midframe();
    test_reset_midframe();
    test_div1_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
